// File: rtl/serial_parallel.sv
// serial_parallel: receive-side deserializer for the parallel_serial stream.
// Hunts for the idle comma to find byte alignment, locks after LOCK_COUNT
// consecutive aligned commas, then delivers every non-comma byte with a
// valid flag. Single clock domain, one byte period = 8 clk_32f cycles,
// serial order MSB first.
//
// Optional build macro: SERIAL_PARALLEL_BYTE_CNT_EN
//   When defined, adds a 16-bit byte_cnt output counting delivered data
//   bytes (wraps at 16'hFFFF). When undefined the port and counter are absent.
module serial_parallel #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
  output logic [15:0] byte_cnt,
`endif
  output logic        active
);

  // Alignment state machine: sliding search, boundary-checked alignment,
  // and the locked data-delivery state.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Lock threshold narrowed to the width of the comma counter.
  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t      state_q,     state_d;
  // Only seven history bits are kept; the eighth bit of every candidate
  // byte is the bit arriving this cycle.
  logic [6:0]  shreg_q,     shreg_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [3:0]  bc_cnt_q,    bc_cnt_d;
  logic [7:0]  data_out_q,  data_out_d;
  logic        valid_out_q, valid_out_d;
  logic        active_q,    active_d;
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
  logic [15:0] byte_cnt_q,  byte_cnt_d;
`endif

  logic [7:0]  word;
  logic        is_comma;
  logic        boundary;

  // Candidate byte including the bit on the wire right now, so a byte is
  // recognised on the same edge that samples its last bit.
  always_comb begin
    word     = {shreg_q, data_in};
    is_comma = (word == COMMA);
    boundary = (bit_cnt_q == 3'd7);
  end

  // Next-state logic: shift register, bit phase, alignment FSM and outputs.
  always_comb begin
    shreg_d     = {shreg_q[5:0], data_in};
    bit_cnt_d   = bit_cnt_q + 3'd1;
    state_d     = state_q;
    bc_cnt_d    = bc_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    active_d    = active_q;
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
    byte_cnt_d  = byte_cnt_q;
`endif

    case (state_q)
      SEARCH: begin
        // Compare on every cycle regardless of phase; a hit defines the
        // byte phase by restarting the bit counter.
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (LOCK_CNT4 == 4'd1) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        // Only whole aligned bytes count; any non-comma drops the hunt.
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_d == LOCK_CNT4) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = SEARCH;
          end
        end
      end

      LOCKED: begin
        // Data bytes are presented for a full byte period; an idle comma
        // clears valid but leaves the last data byte visible.
        if (boundary) begin
          if (is_comma) begin
            valid_out_d = 1'b0;
          end else begin
            data_out_d  = word;
            valid_out_d = 1'b1;
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
            byte_cnt_d  = byte_cnt_q + 16'd1;
`endif
          end
        end
      end

      default: begin
        state_d  = SEARCH;
        bc_cnt_d = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q     <= SEARCH;
      shreg_q     <= 7'd0;
      bit_cnt_q   <= 3'd0;
      bc_cnt_q    <= 4'd0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      active_q    <= 1'b0;
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
      byte_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      bc_cnt_q    <= bc_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      active_q    <= active_d;
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
      byte_cnt_q  <= byte_cnt_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign active    = active_q;
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
  assign byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parallel.sv
// tb_serial_parallel: table-driven bench for serial_parallel. Bytes are sent
// MSB first through a small serializer task; outputs are checked after every
// bit (held values mid-byte, new values on the final bit of each byte).
module tb_serial_parallel;

  logic        clk_32f;
  logic        reset;
  logic        data_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        active;
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  int errors;
  int checks;

  typedef struct {
    logic [7:0]  tx;
    logic [7:0]  exp_data;
    logic        exp_valid;
    logic        exp_active;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [0:20];

  // Expected outputs currently held between byte boundaries.
  logic [7:0]  prev_data;
  logic        prev_valid;
  logic        prev_active;
  logic [15:0] prev_cnt;

  serial_parallel dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
    .byte_cnt  (byte_cnt),
`endif
    .active    (active)
  );

  // Free-running bit clock.
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  function automatic vec_t mk(input logic [7:0] tx, input logic [7:0] d,
                              input logic v, input logic a, input logic [15:0] c);
    vec_t r;
    r.tx = tx; r.exp_data = d; r.exp_valid = v; r.exp_active = a; r.exp_cnt = c;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] ed,
                             input logic ev, input logic ea, input logic [15:0] ec);
    checks++;
    if (data_out !== ed) begin
      errors++;
      $display("[TB] FAIL %s data_out got %h want %h", name, data_out, ed);
    end
    checks++;
    if (valid_out !== ev) begin
      errors++;
      $display("[TB] FAIL %s valid_out got %b want %b", name, valid_out, ev);
    end
    checks++;
    if (active !== ea) begin
      errors++;
      $display("[TB] FAIL %s active got %b want %b", name, active, ea);
    end
`ifdef SERIAL_PARALLEL_BYTE_CNT_EN
    checks++;
    if (byte_cnt !== ec) begin
      errors++;
      $display("[TB] FAIL %s byte_cnt got %0d want %0d", name, byte_cnt, ec);
    end
`else
    if (ec == 16'hFFFF && name == "") $display("[TB] unused count %0d", ec);
`endif
  endtask

  task automatic clearPrev();
    prev_data = 8'h00; prev_valid = 1'b0; prev_active = 1'b0; prev_cnt = 16'd0;
  endtask

  // One serial bit, sampled by the DUT on the next rising edge.
  task automatic sendBit(input logic b, input string name);
    data_in = b;
    @(posedge clk_32f);
    #1;
    checkOutput(name, prev_data, prev_valid, prev_active, prev_cnt);
  endtask

  // Serialize vectors first..last MSB first; outputs must hold for the first
  // seven bits and take the record's values on the eighth.
  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      for (int b = 7; b >= 0; b--) begin
        data_in = vecs[i].tx[b];
        @(posedge clk_32f);
        #1;
        if (b != 0)
          checkOutput($sformatf("vec%0d_hold", i), prev_data, prev_valid, prev_active, prev_cnt);
        else
          checkOutput($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                      vecs[i].exp_active, vecs[i].exp_cnt);
      end
      prev_data   = vecs[i].exp_data;
      prev_valid  = vecs[i].exp_valid;
      prev_active = vecs[i].exp_active;
      prev_cnt    = vecs[i].exp_cnt;
    end
  endtask

  // Main sequence: reset, lock, data delivery, mid-byte reset, relock.
  initial begin
    logic [7:0] partial;
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    data_in = 1'b0;
    clearPrev();

    // Lock from garbage, then data FF EE AA, idle BC, data CC.
    vecs[0]  = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[1]  = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[2]  = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[3]  = mk(8'hBC, 8'h00, 1'b0, 1'b1, 16'd0);
    vecs[4]  = mk(8'hFF, 8'hFF, 1'b1, 1'b1, 16'd1);
    vecs[5]  = mk(8'hEE, 8'hEE, 1'b1, 1'b1, 16'd2);
    vecs[6]  = mk(8'hAA, 8'hAA, 1'b1, 1'b1, 16'd3);
    vecs[7]  = mk(8'hBC, 8'hAA, 1'b0, 1'b1, 16'd3);
    vecs[8]  = mk(8'hCC, 8'hCC, 1'b1, 1'b1, 16'd4);
    // Broken alignment (BC BC 12) must restart the comma count.
    vecs[9]  = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[10] = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[11] = mk(8'h12, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[12] = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[13] = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[14] = mk(8'hBC, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[15] = mk(8'hBC, 8'h00, 1'b0, 1'b1, 16'd0);
    vecs[16] = mk(8'h11, 8'h11, 1'b1, 1'b1, 16'd1);
    vecs[17] = mk(8'h22, 8'h22, 1'b1, 1'b1, 16'd2);
    vecs[18] = mk(8'h33, 8'h33, 1'b1, 1'b1, 16'd3);
    vecs[19] = mk(8'hBC, 8'h33, 1'b0, 1'b1, 16'd3);
    vecs[20] = mk(8'hBC, 8'h33, 1'b0, 1'b1, 16'd3);

    // Reset held for four cycles with random serial data.
    for (int i = 0; i < 4; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      checkOutput($sformatf("reset%0d", i), 8'h00, 1'b0, 1'b0, 16'd0);
    end
    reset = 1'b1;

    $display("[TB] garbage bits then lock sequence");
    sendBit(1'b1, "garbage0");
    sendBit(1'b0, "garbage1");
    sendBit(1'b1, "garbage2");
    applyStimulus(0, 8);

    $display("[TB] one-cycle reset mid-byte while locked");
    partial = 8'h55;
    sendBit(partial[7], "mid0");
    sendBit(partial[6], "mid1");
    sendBit(partial[5], "mid2");
    reset   = 1'b0;
    data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    checkOutput("mid_reset", 8'h00, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    clearPrev();

    $display("[TB] broken alignment then relock and count");
    applyStimulus(9, 20);

    $display("[TB] final reset");
    reset = 1'b0;
    @(posedge clk_32f);
    #1;
    checkOutput("final_reset", 8'h00, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
- Receive-side deserializer directly downstream of parallel_serial; consumes its 1-bit stream at clk_32f.
- Finds byte alignment by hunting for the idle comma (COMMA, 0xBC), locks after LOCK_COUNT consecutive aligned commas, then delivers each non-comma byte as an 8-bit word with a valid flag.
- Single clock domain (clk_32f); one byte period = 8 clk_32f cycles; serial order MSB first.

Parameters:
- COMMA, 8'hBC, idle/alignment character sent by the transmitter when its valid_in is low.
- LOCK_COUNT, 4, consecutive aligned commas required to assert active (legal range 1..15).

Ports:
- clk_32f  input  1  bit clock; all logic on posedge.
- reset  input  1  synchronous, active-low; 0 = reset, sampled on posedge clk_32f.
- data_in  input  1  serial bit from parallel_serial, MSB of each byte first.
- data_out  output  8  last delivered data byte.
- valid_out  output  1  high while data_out holds a data byte for the current byte period.
- active  output  1  high once alignment is locked.

Behaviour:
- Reset (reset==0 at posedge): data_out=8'h00, valid_out=0, active=0, shift register=0, bit_cnt=0, bc_cnt=0, state=SEARCH. Reset wins over all other events, including mid-byte and while LOCKED.
- Shift register: shreg <= {shreg[6:0], data_in} every cycle out of reset. word = {shreg[6:0], data_in} (combinational, includes the current bit).
- bit_cnt: 3-bit counter, increments every cycle, wraps 7->0. "Boundary" = cycle with bit_cnt==7 (word is a complete aligned byte).
- SEARCH (sliding compare every cycle, ignores bit_cnt):
  - word==COMMA: bit_cnt<=0, bc_cnt<=1; if LOCK_COUNT==1 go to LOCKED with active<=1, else go to ALIGN.
  - Otherwise stay in SEARCH.
- ALIGN (compare only at boundary):
  - word==COMMA: bc_cnt<=bc_cnt+1; if bc_cnt+1==LOCK_COUNT go to LOCKED and active<=1 on this edge.
  - word!=COMMA: bc_cnt<=0, go to SEARCH. Sliding compare resumes on the next cycle.
- LOCKED (boundary only):
  - word!=COMMA: data_out<=word, valid_out<=1.
  - word==COMMA: valid_out<=0; data_out holds its previous value.
  - data_out and valid_out are stable for the 8 cycles between boundaries.
  - active stays 1 until reset. There is no lock-loss detection.
- Outputs change only in SEARCH->LOCKED/ALIGN->LOCKED transitions and at LOCKED boundaries. valid_out is 0 in every state except LOCKED.
- Latency: the last bit of a byte is sampled at edge N; data_out/valid_out show that byte after edge N. Phase is 1 cycle after the final bit.
- A data byte equal to COMMA cannot be delivered; the transmitter never sends one as data.
- Non-comma bytes arriving in SEARCH/ALIGN are discarded.

Optional Feature:
- Macro: SERIAL_PARALLEL_BYTE_CNT_EN.
- Defined:
  - Adds output byte_cnt [15:0], reset to 0.
  - Increments at each LOCKED boundary that sets valid_out<=1; wraps 16'hFFFF->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held low 4 cycles with random data_in -> data_out=00, valid_out=0, active=0 throughout. The bench drives an MSB-first serializer model.
- 3 garbage bits (1,0,1), then 4×BC -> active rises on the edge sampling the last bit of the 4th BC. valid_out stays 0.
- Lock established, then bytes FF, EE, AA, then BC, then CC -> data_out=FF/EE/AA each for 8 cycles with valid_out=1; valid_out=0 for the BC period (data_out holds AA); then CC with valid_out=1.
- BC, BC, then 0x12, then 4×BC -> return to SEARCH after 0x12, bc_cnt cleared. active asserts only after the final 4 BCs, not before.
- Reset pulsed low 1 cycle mid-byte while LOCKED -> all outputs 0 next edge; relock requires a fresh 4×BC.
- With SERIAL_PARALLEL_BYTE_CNT_EN: lock, then 3 data bytes and 2 BCs -> byte_cnt=3. Reset -> byte_cnt=0.
